pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the CPU fetch stage. It holds the architectural fetch PC and advances it sequentially by a fixed step. It accepts branch redirects and trap redirects, buffering one redirect that arrives while fetch is stalled. It also keeps a saturating count of non-sequential PC changes for performance debug.

---
 rtl/pc_sequencer.sv | 97 +++++++++
 tb/tb_pc_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential stepping, branch/trap redirects with a
// one-deep buffer for redirects that arrive while stalled, and a saturating redirect counter.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 'h60,
  parameter int               STEP         = 4,
  parameter int               CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 advance,
  input  logic                 redirect_valid,
  input  logic [WIDTH-1:0]     redirect_target,
  input  logic                 trap_valid,
  input  logic [WIDTH-1:0]     trap_vector,
  input  logic                 count_clr,
  output logic [WIDTH-1:0]     pc_o,
  output logic                 pending_o,
  output logic                 misaligned_o,
  output logic [CNT_WIDTH-1:0] redirect_count_o
);

  logic [WIDTH-1:0]     pc_q;
  logic                 pend_valid;
  logic [WIDTH-1:0]     pend_target;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic                 req_valid;
  logic [WIDTH-1:0]     req_target;
  logic                 jump;
  logic [WIDTH-1:0]     jump_target;
  logic [WIDTH-1:0]     pc_next;
  logic                 cnt_inc;

  always_comb begin
    req_valid   = trap_valid | redirect_valid;
    req_target  = trap_valid ? trap_vector : redirect_target;
    jump        = 1'b0;
    jump_target = req_target;
    pc_next     = pc_q;
    if (!stall) begin
      if (req_valid) begin
        jump        = 1'b1;
        jump_target = req_target;
      end else if (pend_valid) begin
        jump        = 1'b1;
        jump_target = pend_target;
      end
      if (jump) begin
        pc_next = jump_target;
      end else if (advance) begin
        pc_next = pc_q + WIDTH'(STEP);
      end
    end
    // A redirect that lands on the current PC is not a discontinuity.
    cnt_inc = jump && (jump_target != pc_q) && !(&cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_VECTOR;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      cnt_q       <= '0;
    end else begin
      pc_q <= pc_next;
      if (stall) begin
        if (req_valid) begin
          pend_valid  <= 1'b1;
          pend_target <= req_target;
        end
      end else begin
        pend_valid <= 1'b0;
      end
      if (count_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pc_o             = pc_q;
  assign pending_o        = pend_valid;
  assign redirect_count_o = cnt_q;

  generate
    if (STEP > 1) begin : g_misaligned
      localparam int SB = $clog2(STEP);
      assign misaligned_o = |pc_q[SB-1:0];
    end else begin : g_aligned
      assign misaligned_o = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer; a second instance with a 2-bit
// counter shares the stimulus so saturation is observable.
module tb_pc_sequencer;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        advance = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_vector = '0;
  logic        count_clr = 1'b0;

  logic [31:0] pc_o, pc2;
  logic        pending_o, pend2;
  logic        misaligned_o, mis2;
  logic [31:0] redirect_count_o;
  logic [1:0]  cnt2;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .advance(advance),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector), .count_clr(count_clr),
    .pc_o(pc_o), .pending_o(pending_o), .misaligned_o(misaligned_o),
    .redirect_count_o(redirect_count_o)
  );

  pc_sequencer #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .stall(stall), .advance(advance),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector), .count_clr(count_clr),
    .pc_o(pc2), .pending_o(pend2), .misaligned_o(mis2),
    .redirect_count_o(cnt2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_tgt;
  longint      m_cnt, m_cnt2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h60; m_pend = 0; m_pend_tgt = '0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic check_all();
    chk("pc", pc_o, m_pc);
    chk("pending", pending_o, m_pend);
    chk("count", redirect_count_o, m_cnt);
    chk("misaligned", misaligned_o, (m_pc % STEP) != 0);
    chk("sat_count", cnt2, m_cnt2);
  endtask

  // One clock with the given inputs, then model update and comparison.
  task automatic cyc(input bit st, input bit ad, input bit rv, input logic [31:0] rt,
                     input bit tv, input logic [31:0] tt, input bit cc);
    bit          req, moved;
    logic [31:0] tgt, new_pc;
    stall = st; advance = ad; redirect_valid = rv; redirect_target = rt;
    trap_valid = tv; trap_vector = tt; count_clr = cc;
    @(posedge clk);
    req = tv || rv;
    tgt = tv ? tt : rt;
    new_pc = m_pc;
    moved = 0;
    if (st) begin
      if (req) begin m_pend = 1; m_pend_tgt = tgt; end
    end else if (req) begin
      new_pc = tgt; m_pend = 0; moved = 1;
    end else if (m_pend) begin
      new_pc = m_pend_tgt; m_pend = 0; moved = 1;
    end else if (ad) begin
      new_pc = m_pc + 32'(STEP);
    end
    if (cc) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (moved && new_pc != m_pc) begin
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    m_pc = new_pc;
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_pc", pc_o, 32'h60);
    rst = 1'b0;

    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0);
    chk("step3_pc", pc_o, 32'h6C);

    cyc(0, 0, 1, 32'h200, 0, 0, 0);
    chk("redir_pc", pc_o, 32'h200);
    chk("redir_cnt", redirect_count_o, 1);
    cyc(0, 0, 1, 32'h200, 0, 0, 0);
    chk("same_pc_cnt", redirect_count_o, 1);

    cyc(1, 1, 1, 32'h300, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h80, 0);
    chk("stall_hold", pc_o, 32'h200);
    chk("stall_pend", pending_o, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("release_pc", pc_o, 32'h80);
    chk("release_cnt", redirect_count_o, 2);

    cyc(0, 0, 1, 32'h400, 1, 32'h80, 0);
    chk("trap_wins", pc_o, 32'h80);
    cyc(1, 0, 1, 32'h300, 0, 0, 0);
    cyc(0, 0, 1, 32'h500, 0, 0, 0);
    chk("live_beats_pend", pc_o, 32'h500);

    cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("wrap", pc_o, 32'h0);

    for (int i = 1; i <= 5; i++) cyc(0, 0, 1, 32'(i * 16), 0, 0, 0);
    chk("saturate", cnt2, 2'd3);
    cyc(0, 0, 1, 32'h60, 0, 0, 1);
    chk("clr_cnt", redirect_count_o, 0);
    chk("clr_sat", cnt2, 0);

    cyc(0, 0, 1, 32'h102, 0, 0, 0);
    chk("misaligned", misaligned_o, 1);
    cyc(1, 0, 1, 32'h700, 0, 0, 0);
    chk("pre_rst_pend", pending_o, 1);

    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
    check_all();

    for (int i = 0; i < 400; i++) begin
      logic [31:0] rt, tt;
      rt = ($urandom % 3 == 0) ? m_pc : ($urandom & 32'hFFFF_FFFC);
      tt = ($urandom % 4 == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      cyc($urandom % 4 == 0, $urandom % 2 == 0, $urandom % 5 == 0, rt,
          $urandom % 9 == 0, tt, $urandom % 40 == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
